// File: rtl/mem_access_seq.sv
// mem_access_seq: byte/halfword load-store sequencer driving a byte-wide data memory.
// Every memory-side output is registered so nothing combinational reaches the memory from the request inputs.
module mem_access_seq (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        IsStore,
    input  logic        Wide,
    input  logic [7:0]  BaseAddr,
    input  logic [15:0] StoreData,
    input  logic [7:0]  MemRdData,
    output logic [7:0]  MemAddr,
    output logic [7:0]  MemWrData,
    output logic        MemWrEn,
    output logic        MemToReg,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] LoadData
);
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    state_t     state;
    logic       is_store;
    logic       wide;
    logic [7:0] base;
    logic [7:0] data_hi;
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            is_store  <= 1'b0;
            wide      <= 1'b0;
            base      <= '0;
            data_hi   <= '0;
            MemAddr   <= '0;
            MemWrData <= '0;
            MemWrEn   <= 1'b0;
            MemToReg  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            LoadData  <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    state     <= LO;
                    is_store  <= IsStore;
                    wide      <= Wide;
                    base      <= BaseAddr;
                    data_hi   <= StoreData[15:8];
                    Busy      <= 1'b1;
                    MemAddr   <= BaseAddr;
                    MemWrEn   <= IsStore;
                    MemWrData <= IsStore ? StoreData[7:0] : 8'h00;
                    MemToReg  <= !IsStore;
                end
                LO: begin
                    // a byte load zero-extends; a wide load refills the high byte in HI
                    if (!is_store) LoadData <= {wide ? LoadData[15:8] : 8'h00, MemRdData};
                    state     <= wide ? HI : DONE;
                    Done      <= !wide;
                    MemAddr   <= wide ? base + 8'd1 : 8'h00;
                    MemWrEn   <= wide && is_store;
                    MemWrData <= (wide && is_store) ? data_hi : 8'h00;
                    MemToReg  <= wide && !is_store;
                end
                HI: begin
                    if (!is_store) LoadData[15:8] <= MemRdData;
                    state     <= DONE;
                    Done      <= 1'b1;
                    MemAddr   <= '0;
                    MemWrEn   <= 1'b0;
                    MemWrData <= '0;
                    MemToReg  <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed requests with a queue-based scoreboard for memory writes and completions.
module tb_mem_access_seq;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        IsStore = 1'b0;
    logic        Wide = 1'b0;
    logic [7:0]  BaseAddr = '0;
    logic [15:0] StoreData = '0;
    logic [7:0]  MemRdData;
    logic [7:0]  MemAddr;
    logic [7:0]  MemWrData;
    logic        MemWrEn;
    logic        MemToReg;
    logic        Busy;
    logic        Done;
    logic [15:0] LoadData;

    mem_access_seq dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .IsStore(IsStore), .Wide(Wide),
        .BaseAddr(BaseAddr), .StoreData(StoreData), .MemRdData(MemRdData),
        .MemAddr(MemAddr), .MemWrData(MemWrData), .MemWrEn(MemWrEn),
        .MemToReg(MemToReg), .Busy(Busy), .Done(Done), .LoadData(LoadData)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [256];
    assign MemRdData = mem[MemAddr];
    always @(posedge Clk) if (MemWrEn) mem[MemAddr] <= MemWrData;

    typedef struct {int cyc; logic [7:0] addr; logic [7:0] data;} wr_t;
    typedef struct {int cyc; int mtr; logic [15:0] ld;} dn_t;
    wr_t wq[$];
    dn_t dq[$];
    wr_t w;
    dn_t d;
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int mtr_cnt = 0;

    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // monitor: pops expectations whenever the DUT writes memory or signals completion
    always @(negedge Clk) begin
        if (MemToReg) mtr_cnt++;
        if (MemWrEn) begin
            if (wq.size() == 0) fail("unexpected_write");
            else begin
                w = wq.pop_front();
                chk("wr_addr", 32'(MemAddr), 32'(w.addr));
                chk("wr_data", 32'(MemWrData), 32'(w.data));
                chk("wr_cycle", 32'(cyc), 32'(w.cyc));
            end
        end
        if (MemToReg) chk("load_no_write", 32'({MemWrEn, MemWrData}), 32'd0);
        if (!Busy) chk("idle_outputs", 32'({MemAddr, MemWrData, MemWrEn, MemToReg, Done}), 32'd0);
        if (Done) begin
            if (dq.size() == 0) fail("unexpected_done");
            else begin
                d = dq.pop_front();
                chk("load_data", 32'(LoadData), 32'(d.ld));
                chk("done_cycle", 32'(cyc), 32'(d.cyc));
                chk("memtoreg_cycles", 32'(mtr_cnt), 32'(d.mtr));
            end
            mtr_cnt = 0;
        end
    end

    task automatic expect_req(input logic st, input logic wd, input logic [7:0] a,
                              input logic [15:0] sd, input logic [15:0] ld, input int c);
        logic [7:0] a1;
        a1 = a + 8'd1;
        if (st) begin
            wq.push_back('{c + 1, a, sd[7:0]});
            if (wd) wq.push_back('{c + 2, a1, sd[15:8]});
        end
        dq.push_back('{wd ? c + 3 : c + 2, st ? 0 : (wd ? 2 : 1), ld});
    endtask

    task automatic drive(input logic st, input logic wd, input logic [7:0] a, input logic [15:0] sd);
        Start = 1'b1;
        IsStore = st;
        Wide = wd;
        BaseAddr = a;
        StoreData = sd;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (Busy) fail("idle_timeout");
    endtask

    task automatic req(input logic st, input logic wd, input logic [7:0] a,
                       input logic [15:0] sd, input logic [15:0] ld);
        expect_req(st, wd, a, sd, ld, cyc);
        drive(st, wd, a, sd);
        @(negedge Clk);
        Start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h55;
        mem[8'h01] = 8'h05;
        mem[8'h30] = 8'h80;
        mem[8'h40] = 8'hFF;
        mem[8'h41] = 8'hFF;
        mem[8'h20] = 8'h66;
        mem[8'h21] = 8'h77;
        Start = 1'b1;
        #12;
        chk("reset_mem_side", 32'({MemAddr, MemWrData, MemWrEn, MemToReg}), 32'd0);
        chk("reset_status", 32'({Busy, Done, LoadData}), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        req(1'b0, 1'b1, 8'h00, 16'h0000, 16'h0555);
        req(1'b1, 1'b0, 8'h10, 16'h12A3, 16'h0555);
        chk("byte_store_mem", 32'(mem[8'h10]), 32'h0000_00A3);
        req(1'b1, 1'b1, 8'hFF, 16'hBEEF, 16'h0555);
        chk("wrap_store_lo", 32'(mem[8'hFF]), 32'h0000_00EF);
        chk("wrap_store_hi", 32'(mem[8'h00]), 32'h0000_00BE);
        req(1'b0, 1'b1, 8'h40, 16'h0000, 16'hFFFF);
        req(1'b0, 1'b0, 8'h30, 16'h0000, 16'h0080);
        c = cyc;
        expect_req(1'b0, 1'b1, 8'h00, 16'h0000, 16'h05BE, c);
        expect_req(1'b0, 1'b1, 8'h00, 16'h0000, 16'h05BE, c + 4);
        drive(1'b0, 1'b1, 8'h00, 16'h0000);
        repeat (6) @(negedge Clk);
        Start = 1'b0;
        wait_idle();
        c = cyc;
        wq.push_back('{c + 1, 8'h20, 8'h34});
        drive(1'b1, 1'b1, 8'h20, 16'h1234);
        @(negedge Clk);
        Start = 1'b0;
        @(posedge Clk);
        #2;
        chk("hi_wren_before_reset", 32'(MemWrEn), 32'd1);
        Reset = 1'b0;
        #1;
        chk("async_reset_mem_side", 32'({MemAddr, MemWrData, MemWrEn, MemToReg}), 32'd0);
        chk("async_reset_status", 32'({Busy, Done, LoadData}), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);
        chk("interrupted_lo_written", 32'(mem[8'h20]), 32'h0000_0034);
        chk("interrupted_hi_untouched", 32'(mem[8'h21]), 32'h0000_0077);
        chk("pending_writes", 32'(wq.size()), 32'd0);
        chk("pending_dones", 32'(dq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
